// File: rtl/turbo_intlv_pkg.sv
// Shared turbo interleaver definitions: frame length, permutation table and bank states.
// Used by both the interleaver and block_deinterleaver.
package turbo_intlv_pkg;

  localparam int FRAME_LEN = 5;
  localparam int CNT_W     = 3;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  // Interleaved position k carries natural index perm(k).
  function automatic logic [CNT_W-1:0] perm(input logic [CNT_W-1:0] k);
    case (k)
      3'd0:    perm = 3'd3;
      3'd1:    perm = 3'd1;
      3'd2:    perm = 3'd2;
      3'd3:    perm = 3'd4;
      3'd4:    perm = 3'd0;
      default: perm = 3'd0;
    endcase
  endfunction

  function automatic bank_state_t bank_next(input bank_state_t st,
                                            input logic wr, input logic wr_last,
                                            input logic rd, input logic rd_last);
    case (st)
      BANK_EMPTY: begin
        if (wr) bank_next = wr_last ? BANK_FULL : BANK_FILLING;
        else    bank_next = BANK_EMPTY;
      end
      BANK_FILLING: begin
        if (wr && wr_last) bank_next = BANK_FULL;
        else               bank_next = BANK_FILLING;
      end
      BANK_FULL: begin
        if (rd) bank_next = rd_last ? BANK_EMPTY : BANK_DRAINING;
        else    bank_next = BANK_FULL;
      end
      BANK_DRAINING: begin
        if (rd && rd_last) bank_next = BANK_EMPTY;
        else               bank_next = BANK_DRAINING;
      end
      default: bank_next = BANK_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/deint_bank_ram.sv
// One frame buffer of the deinterleaver: FRAME_LEN x SYM_W register file,
// one synchronous write port and one combinational read port.
module deint_bank_ram
  import turbo_intlv_pkg::*;
#(
  parameter int SYM_W = 7
) (
  input  logic             clk_p_i,
  input  logic             reset_p_i,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] wr_addr_i,
  input  logic [SYM_W-1:0] wr_data_i,
  input  logic [CNT_W-1:0] rd_addr_i,
  output logic [SYM_W-1:0] rd_data_o
);

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FRAME_LEN);

  logic [SYM_W-1:0] mem_q [FRAME_LEN];

  // Storage array, cleared on reset so stale symbols can never leak out.
  always_ff @(posedge clk_p_i) begin
    if (reset_p_i) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i && (wr_addr_i < DEPTH)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port with out-of-range addresses returning zero.
  always_comb begin
    if (rd_addr_i < DEPTH) begin
      rd_data_o = mem_q[rd_addr_i];
    end else begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/block_deinterleaver.sv
// Ping-pong block deinterleaver for the 5-symbol turbo permutation.
// Optional framing check enabled by defining DEINT_LAST_CHECK_EN.
module block_deinterleaver
  import turbo_intlv_pkg::*;
#(
  parameter int SYM_W = 7
) (
  input  logic             clk_p_i,
  input  logic             reset_p_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [SYM_W-1:0] in_data_i,
`ifdef DEINT_LAST_CHECK_EN
  input  logic             in_last_i,
  output logic             frame_err_o,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [SYM_W-1:0] out_data_o,
  output logic             out_last_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  bank_state_t      bank_st_q [2];
  bank_state_t      bank_st_d [2];
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

  bank_state_t      wr_st_s, rd_st_s;
  logic             wr_fire_s, rd_fire_s, wr_last_s, rd_last_s;
  logic [1:0]       bank_wr_en_s, bank_rd_en_s;
  logic [CNT_W-1:0] wr_addr_s;
  logic [SYM_W-1:0] bank_rd_data_s [2];

  assign wr_st_s   = bank_st_q[wr_bank_q];
  assign rd_st_s   = bank_st_q[rd_bank_q];
  assign wr_last_s = (wr_cnt_q == LAST_IDX);
  assign rd_last_s = (rd_cnt_q == LAST_IDX);
  assign wr_addr_s = perm(wr_cnt_q);

  assign in_ready_o  = !reset_p_i && (wr_st_s != BANK_FULL) && (wr_st_s != BANK_DRAINING);
  assign out_valid_o = !reset_p_i && ((rd_st_s == BANK_FULL) || (rd_st_s == BANK_DRAINING));
  assign wr_fire_s   = in_valid_i && in_ready_o;
  assign rd_fire_s   = out_valid_o && out_ready_i;

  assign bank_wr_en_s[0] = wr_fire_s && (wr_bank_q == 1'b0);
  assign bank_wr_en_s[1] = wr_fire_s && (wr_bank_q == 1'b1);
  assign bank_rd_en_s[0] = rd_fire_s && (rd_bank_q == 1'b0);
  assign bank_rd_en_s[1] = rd_fire_s && (rd_bank_q == 1'b1);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    deint_bank_ram #(
      .SYM_W(SYM_W)
    ) u_ram (
      .clk_p_i  (clk_p_i),
      .reset_p_i(reset_p_i),
      .wr_en_i  (bank_wr_en_s[b]),
      .wr_addr_i(wr_addr_s),
      .wr_data_i(in_data_i),
      .rd_addr_i(rd_cnt_q),
      .rd_data_o(bank_rd_data_s[b])
    );
  end

  // Outputs come straight from bank and counter flops, so they hold while stalled.
  assign out_data_o = out_valid_o ? bank_rd_data_s[rd_bank_q] : '0;
  assign out_last_o = out_valid_o && rd_last_s;

  // Write/read counters, bank pointers and per-bank state next values.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    if (wr_fire_s) begin
      if (wr_last_s) begin
        wr_cnt_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_cnt_d  = wr_cnt_q + CNT_ONE;
        wr_bank_d = wr_bank_q;
      end
    end else begin
      wr_cnt_d  = wr_cnt_q;
      wr_bank_d = wr_bank_q;
    end
    if (rd_fire_s) begin
      if (rd_last_s) begin
        rd_cnt_d  = '0;
        rd_bank_d = ~rd_bank_q;
      end else begin
        rd_cnt_d  = rd_cnt_q + CNT_ONE;
        rd_bank_d = rd_bank_q;
      end
    end else begin
      rd_cnt_d  = rd_cnt_q;
      rd_bank_d = rd_bank_q;
    end
    for (int b = 0; b < 2; b++) begin
      bank_st_d[b] = bank_next(bank_st_q[b], bank_wr_en_s[b], wr_last_s,
                               bank_rd_en_s[b], rd_last_s);
    end
  end

  // State registers; reset discards any partial or pending frame.
  always_ff @(posedge clk_p_i) begin
    if (reset_p_i) begin
      bank_st_q[0] <= BANK_EMPTY;
      bank_st_q[1] <= BANK_EMPTY;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
    end else begin
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
    end
  end

`ifdef DEINT_LAST_CHECK_EN
  logic frame_err_q, frame_err_d;

  // Sticky flag: upstream last marker must coincide with the 5th symbol of each frame.
  always_comb begin
    frame_err_d = frame_err_q;
    if (wr_fire_s && (in_last_i != wr_last_s)) begin
      frame_err_d = 1'b1;
    end else begin
      frame_err_d = frame_err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clk_p_i) begin
    if (reset_p_i) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err_o = frame_err_q;
`endif

endmodule

// File: tb/tb_block_deinterleaver.sv
// Directed self-checking bench for block_deinterleaver (framing check covered
// when DEINT_LAST_CHECK_EN is defined).
module tb_block_deinterleaver;

  localparam int SYM_W = 7;

  logic             clk = 1'b0;
  logic             reset_p;
  logic             in_valid, in_ready, in_last;
  logic [SYM_W-1:0] in_data;
  logic             out_valid, out_ready, out_last;
  logic [SYM_W-1:0] out_data;
`ifdef DEINT_LAST_CHECK_EN
  logic             frame_err;
`endif

  int compared   = 0;
  int mismatched = 0;
  int perm_tb [5] = '{3, 1, 2, 4, 0};

  always #5 clk = ~clk;

  block_deinterleaver #(
    .SYM_W(SYM_W)
  ) dut (
    .clk_p_i    (clk),
    .reset_p_i  (reset_p),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
`ifdef DEINT_LAST_CHECK_EN
    .in_last_i  (in_last),
    .frame_err_o(frame_err),
`endif
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_last_o (out_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends one frame whose natural symbol n has value base+n; in_last on slot last_at.
  task automatic send_frame(input int base, input int last_at);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = SYM_W'(base + perm_tb[k]);
      in_last  = (k == last_at);
      check("send_in_ready", 32'(in_ready), 32'd1);
      check("send_no_early_valid", 32'(out_valid), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic read_frame(input int base);
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      check("read_valid", 32'(out_valid), 32'd1);
      check("read_data", 32'(out_data), 32'(base + n));
      check("read_last", 32'(out_last), 32'(n == 4));
      tick();
    end
    check("read_drained", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_p   = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    reset_p = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_out_data", 32'(out_data), 32'd0);
    check("idle_out_last", 32'(out_last), 32'd0);
    @(negedge clk);

    // Single frame: 13,11,12,14,10 in -> 10..14 out, valid one cycle after 5th accept.
    out_ready = 1'b1;
    send_frame(10, 4);
    read_frame(10);

    // Four back-to-back frames with a continuously ready sink.
    for (int c = 0; c < 26; c++) begin
      if (c < 20) begin
        in_valid = 1'b1;
        in_data  = SYM_W'(20 + 8 * (c / 5) + perm_tb[c % 5]);
        in_last  = (c % 5 == 4);
        check("b2b_in_ready", 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      if (c >= 5 && c < 25) begin
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_data", 32'(out_data), 32'(20 + 8 * ((c - 5) / 5) + (c - 5) % 5));
        check("b2b_last", 32'(out_last), 32'((c - 5) % 5 == 4));
      end else begin
        check("b2b_idle_valid", 32'(out_valid), 32'd0);
      end
      tick();
    end

    // Sink stalled while two frames arrive: input blocks, output holds symbol 10.
    out_ready = 1'b0;
    for (int c = 0; c < 15; c++) begin
      in_valid = 1'b1;
      if (c < 10) begin
        in_data = SYM_W'((c < 5 ? 10 : 60) + perm_tb[c % 5]);
        in_last = (c % 5 == 4);
        check("stall_in_ready", 32'(in_ready), 32'd1);
      end else begin
        in_data = 7'd99;
        in_last = 1'b0;
        check("stall_full_block", 32'(in_ready), 32'd0);
      end
      if (c >= 5) begin
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        check("stall_hold_data", 32'(out_data), 32'd10);
      end
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      check("release_valid", 32'(out_valid), 32'd1);
      check("release_data", 32'(out_data), 32'((n < 5 ? 10 : 60) + n % 5));
      check("release_last", 32'(out_last), 32'(n % 5 == 4));
      tick();
    end
    check("release_drained", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);

    // Reset after three symbols of a frame: partial frame must vanish.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = SYM_W'(100 + k);
      tick();
    end
    in_valid = 1'b0;
    reset_p  = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    tick();
    check("midrst_in_ready_held", 32'(in_ready), 32'd0);
    check("midrst_out_valid_held", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_last", 32'(out_last), 32'd0);
    reset_p = 1'b0;
    @(negedge clk);
    send_frame(40, 4);
    read_frame(40);

    // Gappy source and sink against an in-order expectation of three frames.
    begin
      int ii;
      int oi;
      int cyc;
      ii  = 0;
      oi  = 0;
      cyc = 0;
      while (oi < 15 && cyc < 300) begin
        if (ii < 15 && (cyc % 3) != 1) begin
          in_valid = 1'b1;
          in_data  = SYM_W'(70 + 8 * (ii / 5) + perm_tb[ii % 5]);
          in_last  = (ii % 5 == 4);
          if (in_ready) ii++;
        end else begin
          in_valid = 1'b0;
          in_last  = 1'b0;
        end
        out_ready = ((cyc % 4) != 3) && ((cyc % 5) != 0);
        if (out_valid && out_ready) begin
          check("gap_data", 32'(out_data), 32'(70 + 8 * (oi / 5) + oi % 5));
          check("gap_last", 32'(out_last), 32'(oi % 5 == 4));
          oi++;
        end
        tick();
        cyc++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("gap_all_out", 32'(oi), 32'd15);
      check("gap_idle", 32'(out_valid), 32'd0);
    end

`ifdef DEINT_LAST_CHECK_EN
    check("err_clean_run", 32'(frame_err), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = SYM_W'(30 + perm_tb[k]);
      in_last  = (k == 3);
      tick();
      if (k == 3) check("err_set", 32'(frame_err), 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int n = 0; n < 5; n++) begin
      check("err_data", 32'(out_data), 32'(30 + n));
      check("err_sticky", 32'(frame_err), 32'd1);
      tick();
    end
    reset_p = 1'b1;
    tick();
    reset_p = 1'b0;
    check("err_cleared", 32'(frame_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
